systolic_feeder_2by2: RTL



---
 rtl/systolic_feeder_2by2.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/systolic_feeder_2by2.sv
// Sequencer for the 2x2 systolic array: latches A/B on start, clears the PEs,
// streams skewed operands, flushes with zeros and captures the four results.
module systolic_feeder_2by2 #(
    parameter int FLUSH_CYCLES = 2,
    parameter int W            = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [4*W-1:0] mat_a,
    input  logic [4*W-1:0] mat_b,
    input  logic [W-1:0]   c1,
    input  logic [W-1:0]   c2,
    input  logic [W-1:0]   c3,
    input  logic [W-1:0]   c4,
    output logic [W-1:0]   a1,
    output logic [W-1:0]   a2,
    output logic [W-1:0]   b1,
    output logic [W-1:0]   b2,
    output logic           arr_rst,
    output logic           busy,
    output logic           done,
    output logic [4*W-1:0] result
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] FEED  = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]     state, state_n;
    logic [3:0]     cnt, cnt_n;
    logic           latch;
    logic [4*W-1:0] a_q, b_q;
    logic [W-1:0]   a1_n, a2_n, b1_n, b2_n;

    logic [W-1:0] a00, a01, a10, a11, b00, b01, b10, b11;
    assign a00 = a_q[W-1:0];
    assign a01 = a_q[2*W-1:W];
    assign a10 = a_q[3*W-1:2*W];
    assign a11 = a_q[4*W-1:3*W];
    assign b00 = b_q[W-1:0];
    assign b01 = b_q[2*W-1:W];
    assign b10 = b_q[3*W-1:2*W];
    assign b11 = b_q[4*W-1:3*W];

    // start is a single-cycle request with implicit ready = (state == IDLE);
    // a start seen in any other state is dropped, not queued.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        latch   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CLEAR;
                    latch   = 1'b1;
                end
            end
            CLEAR: begin
                state_n = FEED;
                cnt_n   = 4'd0;
            end
            FEED: begin
                if (cnt == 4'd2) begin
                    state_n = FLUSH;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            FLUSH: begin
                if (cnt == 4'(FLUSH_CYCLES - 1)) begin
                    state_n = DONE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the next state/phase.
    always_comb begin
        a1_n = '0;
        a2_n = '0;
        b1_n = '0;
        b2_n = '0;
        if (state_n == FEED) begin
            case (cnt_n)
                4'd0: begin
                    a1_n = a00;
                    b1_n = b00;
                end
                4'd1: begin
                    a1_n = a01;
                    a2_n = a10;
                    b1_n = b10;
                    b2_n = b01;
                end
                4'd2: begin
                    a2_n = a11;
                    b2_n = b11;
                end
                default: begin
                    a1_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            a1      <= '0;
            a2      <= '0;
            b1      <= '0;
            b2      <= '0;
            arr_rst <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            if (latch) begin
                a_q <= mat_a;
                b_q <= mat_b;
            end
            a1      <= a1_n;
            a2      <= a2_n;
            b1      <= b1_n;
            b2      <= b2_n;
            arr_rst <= (state_n == CLEAR);
            busy    <= (state_n != IDLE);
            done    <= (state_n == DONE);
            if (state_n == DONE) begin
                result <= {c4, c3, c2, c1};
            end
        end
    end

endmodule
